snake_body_scanner: RTL

- Read-side companion to the snake segment register file (15 entries × 20 bits, entry = {X[9:0], Y[9:0]} top-left pixel of a segment).
- On a Start pulse, walks the read index over the valid segments and compares each against a query point.
- Reports the first segment whose SEG_SIZE×SEG_SIZE box contains the point.
- Used for head-to-body collision, snake-vs-snake collision and food-spawn rejection, once per frame outside the draw path.

---
 rtl/snake_body_scanner.sv | 114 +++++++++++
 1 files changed

// File: rtl/snake_body_scanner.sv
// snake_body_scanner: walks the segment register file and reports
// the first segment whose box contains a query point.
module snake_body_scanner #(
  parameter int SEG_SIZE = 16,
  parameter int COORD_W  = 10,
  parameter int DEPTH    = 15
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Start,
  input  logic                   Skip_Head,
  input  logic [3:0]             Length,
  input  logic [COORD_W-1:0]     Query_X,
  input  logic [COORD_W-1:0]     Query_Y,
  input  logic [2*COORD_W-1:0]   Entry_Data,
  output logic [3:0]             Access_Index,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Hit,
  output logic [3:0]             Hit_Index
);

  localparam int CW1 = COORD_W + 1;
  localparam logic [CW1-1:0] SEG = CW1'(SEG_SIZE);
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

  state_t state;

  logic [COORD_W-1:0] qx_q;
  logic [COORD_W-1:0] qy_q;
  logic [4:0]         limit_q;

  logic [CW1-1:0] ex;
  logic [CW1-1:0] ey;
  logic [CW1-1:0] qx;
  logic [CW1-1:0] qy;
  logic           match;
  logic [4:0]     lim_in;
  logic [3:0]     first;

  // One extra bit on every operand so Ex+SEG_SIZE never wraps.
  always_comb begin
    ex = {1'b0, Entry_Data[2*COORD_W-1:COORD_W]};
    ey = {1'b0, Entry_Data[COORD_W-1:0]};
    qx = {1'b0, qx_q};
    qy = {1'b0, qy_q};
    match = (qx >= ex) && (qx < ex + SEG) &&
            (qy >= ey) && (qy < ey + SEG);
    lim_in = ({1'b0, Length} > DEPTH_L) ?
             DEPTH_L : {1'b0, Length};
    first = Skip_Head ? 4'd1 : 4'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= ST_IDLE;
      qx_q         <= '0;
      qy_q         <= '0;
      limit_q      <= '0;
      Access_Index <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      Hit          <= 1'b0;
      Hit_Index    <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          Done <= 1'b0;
          if (Start) begin
            qx_q         <= Query_X;
            qy_q         <= Query_Y;
            limit_q      <= lim_in;
            Hit          <= 1'b0;
            Hit_Index    <= '0;
            Access_Index <= first;
            Busy         <= 1'b1;
            if ({1'b0, first} >= lim_in) begin
              state <= ST_DONE;
              Done  <= 1'b1;
            end else begin
              state <= ST_SCAN;
            end
          end
        end
        ST_SCAN: begin
          if (match) begin
            Hit       <= 1'b1;
            Hit_Index <= Access_Index;
            state     <= ST_DONE;
            Done      <= 1'b1;
          end else if ({1'b0, Access_Index} == limit_q - 5'd1) begin
            state <= ST_DONE;
            Done  <= 1'b1;
          end else begin
            Access_Index <= Access_Index + 4'd1;
          end
        end
        ST_DONE: begin
          Done  <= 1'b0;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
